// File: rtl/fb_pkg.sv
// Shared definitions for the frame buffer scheduler.
//   FB_H_RES / FB_V_RES : default frame geometry (320x240).
//   X_W / Y_W           : widths of the video pixel coordinates.
//   ROW_STRIDE_HI/LO    : shift amounts so that row*320 = (row<<8) + (row<<6).
//   fb_state_e          : RAM ownership states.
package fb_pkg;

  localparam int unsigned FB_H_RES = 320;
  localparam int unsigned FB_V_RES = 240;

  localparam int unsigned X_W = 9;
  localparam int unsigned Y_W = 8;

  localparam int unsigned ROW_STRIDE_HI = 8;
  localparam int unsigned ROW_STRIDE_LO = 6;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,  // zero-fill whole buffer, display blanked
    ST_READ  = 2'd1,  // video readout with scroll offset
    ST_WRITE = 2'd2,  // waterfall line write during lower blanking
    ST_BLANK = 2'd3   // idle until lower blanking ends
  } fb_state_e;

endpackage

// File: rtl/fb_row_addr.sv
// Combinational row/address arithmetic shared by the readout and line-write
// paths.
//   row_sum_i : y + y_offset, always < 2*V_RES
//   row_mod_o : row_sum_i mod V_RES (single compare-subtract)
//   row_i     : row to address
//   col_i     : column to address
//   addr_o    : row_i*H_RES + col_i
module fb_row_addr
  import fb_pkg::*;
#(
  parameter int unsigned H_RES  = FB_H_RES,
  parameter int unsigned V_RES  = FB_V_RES,
  parameter int unsigned ADDR_W = 17
) (
  input  logic [Y_W:0]      row_sum_i,
  output logic [Y_W-1:0]    row_mod_o,
  input  logic [Y_W-1:0]    row_i,
  input  logic [X_W-1:0]    col_i,
  output logic [ADDR_W-1:0] addr_o
);

  localparam logic [Y_W:0] V_RES_W = (Y_W + 1)'(V_RES);

  logic [ADDR_W-1:0] row_ext;
  logic [ADDR_W-1:0] row_base;

  // The sum never reaches 2*V_RES, so one conditional subtract is a full modulo.
  assign row_mod_o = (row_sum_i >= V_RES_W) ? Y_W'(row_sum_i - V_RES_W)
                                            : row_sum_i[Y_W-1:0];

  assign row_ext = ADDR_W'(row_i);

  generate
    if (H_RES == (1 << ROW_STRIDE_HI) + (1 << ROW_STRIDE_LO)) begin : g_shift_add
      assign row_base = (row_ext << ROW_STRIDE_HI) + (row_ext << ROW_STRIDE_LO);
    end else begin : g_mult
      assign row_base = row_ext * ADDR_W'(H_RES);
    end
  endgenerate

  assign addr_o = row_base + ADDR_W'(col_i);

endmodule

// File: rtl/framebuf_scheduler.sv
// Sole owner of the single-port frame buffer RAM. Sequences power-on or
// requested clears, per-pixel readout with vertical scroll, and one waterfall
// line write per scroll step during lower blanking.
//   clk, resetn           : pixel clock, async active-low reset
//   x, y                  : video pixel coordinates
//   lower_blank           : vertical blanking below the visible area
//   clear_req             : one-cycle clear request (acted on at next blanking)
//   wr_valid/wr_data      : line-producer pixel stream
//   wr_ready              : pixel accepted this cycle
//   ram_addr/wdata/we     : registered RAM port
//   video_blank           : RAM contents invalid, top forces black
//   line_done             : pulse after the last pixel of a line is written
//   overrun               : sticky, a line write was cut short
//   y_offset              : current top row index
module framebuf_scheduler
  import fb_pkg::*;
#(
  parameter int unsigned H_RES      = FB_H_RES,
  parameter int unsigned V_RES      = FB_V_RES,
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SCROLL_DIV = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  input  logic              lower_blank,
  input  logic              clear_req,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              video_blank,
  output logic              line_done,
  output logic              overrun,
  output logic [Y_W-1:0]    y_offset
);

  localparam int unsigned PIX   = H_RES * V_RES;
  localparam int unsigned CLR_W = ADDR_W + 1;  // counts one past the last address
  localparam int unsigned FC_W  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  localparam logic [CLR_W-1:0] CLR_END  = CLR_W'(PIX);
  localparam logic [X_W-1:0]   COL_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0]   ROW_LAST = Y_W'(V_RES - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(SCROLL_DIV - 1);

  fb_state_e         state_q, state_d;
  logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;
  logic              line_done_q, line_done_d;
  logic              overrun_q, overrun_d;
  logic              video_blank_q, video_blank_d;
  logic [Y_W-1:0]    y_offset_q, y_offset_d;
  logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic              clr_pend_q, clr_pend_d;
  logic [X_W-1:0]    col_q, col_d;

  // Readout pipeline stage 1 and blanking edge detector.
  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    row_q;
  logic              lb_q;

  logic [Y_W:0]      row_sum;
  logic [Y_W-1:0]    row_mod;
  logic [Y_W-1:0]    row_sel;
  logic [X_W-1:0]    col_sel;
  logic [ADDR_W-1:0] row_addr;
  logic              lb_rise;
  logic              clr_now;

  assign row_sum = {1'b0, y} + {1'b0, y_offset_q};
  assign lb_rise = lower_blank & ~lb_q;

  // One address generator: the write path addresses the freshly scrolled top
  // row, the read path the registered stage-1 row.
  assign row_sel = (state_q == ST_WRITE) ? y_offset_q : row_q;
  assign col_sel = (state_q == ST_WRITE) ? col_q      : x_q;

  fb_row_addr #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W)
  ) u_row_addr (
    .row_sum_i (row_sum),
    .row_mod_o (row_mod),
    .row_i     (row_sel),
    .col_i     (col_sel),
    .addr_o    (row_addr)
  );

  // Ready drops in the same cycle blanking ends, so a late beat is refused.
  assign wr_ready = (state_q == ST_WRITE) && lower_blank;
  assign clr_now  = clr_pend_q | clear_req;

  // NOTE: sequential state uses <= so every register samples pre-edge values
  // regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q   <= '0;
      row_q <= '0;
      lb_q  <= 1'b0;
    end else begin
      x_q   <= x;
      row_q <= row_mod;
      lb_q  <= lower_blank;
    end
  end

  // NOTE: every _d gets a default before the case so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    ram_we_d      = 1'b0;
    line_done_d   = 1'b0;
    overrun_d     = overrun_q;
    video_blank_d = video_blank_q;
    y_offset_d    = y_offset_q;
    frame_cnt_d   = frame_cnt_q;
    clr_pend_d    = clr_pend_q;
    col_d         = col_q;

    unique case (state_q)
      ST_CLEAR: begin
        if (clr_cnt_q == CLR_END) begin
          state_d       = ST_READ;
          video_blank_d = 1'b0;
          y_offset_d    = '0;
          frame_cnt_d   = '0;
        end else begin
          ram_we_d    = 1'b1;
          ram_addr_d  = clr_cnt_q[ADDR_W-1:0];
          ram_wdata_d = '0;
          clr_cnt_d   = clr_cnt_q + 1'b1;
        end
      end

      ST_READ: begin
        ram_addr_d = row_addr;
        clr_pend_d = clr_now;
        if (lb_rise) begin
          if (clr_now) begin
            // A pending clear wins over a due scroll step.
            state_d       = ST_CLEAR;
            clr_pend_d    = 1'b0;
            clr_cnt_d     = '0;
            video_blank_d = 1'b1;
          end else if (frame_cnt_q == FC_LAST) begin
            state_d     = ST_WRITE;
            frame_cnt_d = '0;
            col_d       = '0;
            y_offset_d  = (y_offset_q == '0) ? ROW_LAST : y_offset_q - 1'b1;
          end else begin
            state_d     = ST_BLANK;
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end

      ST_WRITE: begin
        if (!lower_blank) begin
          overrun_d = 1'b1;
          state_d   = ST_READ;
        end else if (wr_valid) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = row_addr;
          ram_wdata_d = wr_data;
          if (col_q == COL_LAST) begin
            line_done_d = 1'b1;
            state_d     = ST_BLANK;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end

      ST_BLANK: begin
        if (!lower_blank) state_d = ST_READ;
      end

      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_CLEAR;
      clr_cnt_q     <= '0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      ram_we_q      <= 1'b0;
      line_done_q   <= 1'b0;
      overrun_q     <= 1'b0;
      video_blank_q <= 1'b1;
      y_offset_q    <= '0;
      frame_cnt_q   <= '0;
      clr_pend_q    <= 1'b0;
      col_q         <= '0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      ram_we_q      <= ram_we_d;
      line_done_q   <= line_done_d;
      overrun_q     <= overrun_d;
      video_blank_q <= video_blank_d;
      y_offset_q    <= y_offset_d;
      frame_cnt_q   <= frame_cnt_d;
      clr_pend_q    <= clr_pend_d;
      col_q         <= col_d;
    end
  end

  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign ram_we      = ram_we_q;
  assign line_done   = line_done_q;
  assign overrun     = overrun_q;
  assign video_blank = video_blank_q;
  assign y_offset    = y_offset_q;

endmodule
